// File: rtl/tt_checker.sv
`default_nettype none
//============================================================================
// Module      : tt_checker
// Description : Exhaustive truth-table checker for a 3-input / 2-output
//               combinational device. Each sweep drives every vector
//               {A,B,C} = 0..7 for HOLD cycles and samples F1/F2 on the last
//               cycle of each vector. The responses are compared against the
//               expected truth tables EXP_F1 / EXP_F2, where bit i holds the
//               expected output for vector i.
// Ports       : clk      - clock, rising-edge active
//               rst      - synchronous active-high reset
//               start    - one-cycle sweep request (ignored while busy)
//               A, B, C  - registered stimulus vector (A is the MSB)
//               F1, F2   - responses from the device under test
//               busy     - a sweep is in progress
//               done     - a sweep has completed; held until the next
//                          accepted start or reset
//               pass     - valid with done; 1 = no mismatching vectors
//               err_cnt  - number of mismatching vectors (0..8)
//               fail_idx - index of the first mismatching vector
// Revision    : 1.0 - initial release
//============================================================================
module tt_checker #(
    parameter int         HOLD   = 5,
    parameter logic [7:0] EXP_F1 = 8'hE8,
    parameter logic [7:0] EXP_F2 = 8'h96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    input  logic       F1,
    input  logic       F2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_idx
);

    // Last hold cycle of a vector; responses are sampled here.
    localparam logic [7:0] c_hold_last = 8'(HOLD - 1);
    localparam logic [7:0] c_exp_f1    = EXP_F1;
    localparam logic [7:0] c_exp_f2    = EXP_F2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_idx;
    logic [7:0] r_hold_cnt;
    logic [2:0] r_abc;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err_cnt;
    logic [2:0] r_fail_idx;

    // A vector counts as one error even when both outputs are wrong.
    logic       w_mis;
    logic [3:0] w_err_next;

    assign w_mis      = (F1 != c_exp_f1[r_idx]) || (F2 != c_exp_f2[r_idx]);
    assign w_err_next = r_err_cnt + {3'b000, w_mis};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 3'd0;
            r_hold_cnt <= 8'd0;
            r_abc      <= 3'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= 4'd0;
            r_fail_idx <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // DONE keeps the result and the final vector (3'b111)
                    // stable until a new sweep is requested.
                    if (start) begin
                        r_state    <= S_RUN;
                        r_idx      <= 3'd0;
                        r_hold_cnt <= 8'd0;
                        r_abc      <= 3'd0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_err_cnt  <= 4'd0;
                        r_fail_idx <= 3'd0;
                    end
                end

                S_RUN: begin
                    // start is deliberately not looked at here.
                    if (r_hold_cnt == c_hold_last) begin
                        if (w_mis) begin
                            r_err_cnt <= w_err_next;
                            // Only the first mismatch of a sweep is recorded.
                            if (r_err_cnt == 4'd0) begin
                                r_fail_idx <= r_idx;
                            end
                        end
                        if (r_idx == 3'd7) begin
                            // idx stays at 7 so the output vector holds 3'b111.
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 4'd0);
                        end else begin
                            r_idx      <= r_idx + 3'd1;
                            r_abc      <= r_idx + 3'd1;
                            r_hold_cnt <= 8'd0;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign A        = r_abc[2];
    assign B        = r_abc[1];
    assign C        = r_abc[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err_cnt;
    assign fail_idx = r_fail_idx;

endmodule
`default_nettype wire

// File: tb/tb_tt_checker.sv
`default_nettype none
//============================================================================
// Module      : tb_tt_checker
// Description : Scoreboard bench for tt_checker. Two checkers run against a
//               behavioural device model: one with HOLD=5, one with HOLD=1.
//               Each device is described by its actual truth tables; the
//               expected sweep result is derived from those tables directly.
// Revision    : 1.0 - initial release
//============================================================================
module tb_tt_checker;

    typedef struct {
        int pass;
        int err;
        int fidx;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_v;
    logic [1:0]      start_v;
    logic [1:0]      a_v, b_v, c_v;
    logic [1:0]      f1_v, f2_v;
    logic [1:0]      busy_v, done_v, pass_v;
    logic [1:0][3:0] err_v;
    logic [1:0][2:0] fidx_v;
    // Actual truth tables of the device attached to each checker.
    logic [1:0][7:0] tt1, tt2;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected result from the device's truth tables alone.
    function automatic exp_t model(logic [7:0] t1, logic [7:0] t2, int hold);
        exp_t       e;
        logic [7:0] bad;
        bad    = (t1 ^ 8'hE8) | (t2 ^ 8'h96);
        e.err  = 0;
        e.fidx = 0;
        for (int i = 7; i >= 0; i--) begin
            if (bad[i]) begin
                e.err++;
                e.fidx = i;
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        e.lat  = 8 * hold;
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int H = (g == 0) ? 5 : 1;

        tt_checker #(
            .HOLD  (H),
            .EXP_F1(8'hE8),
            .EXP_F2(8'h96)
        ) u_dut (
            .clk     (clk),
            .rst     (rst_v[g]),
            .start   (start_v[g]),
            .A       (a_v[g]),
            .B       (b_v[g]),
            .C       (c_v[g]),
            .F1      (f1_v[g]),
            .F2      (f2_v[g]),
            .busy    (busy_v[g]),
            .done    (done_v[g]),
            .pass    (pass_v[g]),
            .err_cnt (err_v[g]),
            .fail_idx(fidx_v[g])
        );

        assign f1_v[g] = tt1[g][{a_v[g], b_v[g], c_v[g]}];
        assign f2_v[g] = tt2[g][{a_v[g], b_v[g], c_v[g]}];

        // Monitor: tracks busy length and vector stepping, and scores each
        // completed sweep against the front of the scoreboard.
        initial begin
            int   cnt;
            logic pb, pd;
            exp_t e;
            cnt = 0;
            pb  = 1'b0;
            pd  = 1'b0;
            forever begin
                @(negedge clk);
                if (busy_v[g]) begin
                    cnt = pb ? cnt + 1 : 1;
                    check($sformatf("abc_step%0d", g), {a_v[g], b_v[g], c_v[g]}, (cnt - 1) / H);
                end
                if (done_v[g] && !pd) begin
                    if (sb.size() == 0) begin
                        check($sformatf("unexpected_done%0d", g), 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("pass%0d", g), pass_v[g], e.pass);
                        check($sformatf("err_cnt%0d", g), err_v[g], e.err);
                        check($sformatf("fail_idx%0d", g), fidx_v[g], e.fidx);
                        check($sformatf("latency%0d", g), cnt, e.lat);
                        check($sformatf("busy_at_done%0d", g), busy_v[g], 0);
                    end
                end else if (done_v[g]) begin
                    check($sformatf("abc_done%0d", g), {a_v[g], b_v[g], c_v[g]}, 7);
                end
                pb = busy_v[g];
                pd = done_v[g];
            end
        end
    end

    task automatic check_reset(int g);
        check("rst_abc", {a_v[g], b_v[g], c_v[g]}, 0);
        check("rst_busy", busy_v[g], 0);
        check("rst_done", done_v[g], 0);
        check("rst_pass", pass_v[g], 0);
        check("rst_err_cnt", err_v[g], 0);
        check("rst_fail_idx", fidx_v[g], 0);
    endtask

    task automatic pulse(int g);
        @(posedge clk);
        #1 start_v[g] = 1'b1;
        @(posedge clk);
        #1 start_v[g] = 1'b0;
    endtask

    task automatic wait_done(int g, int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done_v[g]) break;
        end
        check("done_timeout", done_v[g], 1);
    endtask

    task automatic sweep(int g, logic [7:0] t1, logic [7:0] t2);
        int hold;
        hold   = (g == 0) ? 5 : 1;
        tt1[g] = t1;
        tt2[g] = t2;
        sb.push_back(model(t1, t2, hold));
        pulse(g);
        wait_done(g, 8 * hold + 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_v   = 2'b11;
        start_v = 2'b00;
        tt1     = {8'hE8, 8'hE8};
        tt2     = {8'h96, 8'h96};
        // Reset must win over a simultaneous start.
        #1 start_v = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset(0);
        check_reset(1);
        #1 start_v = 2'b00;
        rst_v = 2'b00;

        // ---------------- HOLD = 5 ----------------
        sweep(0, 8'hE8, 8'h96);                  // golden loopback
        sweep(0, 8'hE8, 8'h96 ^ 8'h20);          // single fault at 5
        sweep(0, 8'h00, 8'h96 ^ 8'h80);          // F1 stuck-0, both wrong at 7

        // Start at cycle 10 of a running sweep must be ignored.
        tt1[0] = 8'hE8;
        tt2[0] = 8'h96;
        sb.push_back(model(8'hE8, 8'h96, 5));
        pulse(0);
        repeat (8) @(posedge clk);
        pulse(0);
        wait_done(0, 60);

        // Mid-sweep reset at cycle 17, with an error already counted.
        tt2[0] = 8'h96 ^ 8'h01;
        pulse(0);
        repeat (16) @(posedge clk);
        #1 rst_v[0] = 1'b1;
        @(posedge clk);
        #1 rst_v[0] = 1'b0;
        @(negedge clk);
        check_reset(0);
        sweep(0, 8'hE8, 8'h96);

        for (int k = 0; k < 6; k++) begin
            sweep(0, 8'hE8 ^ 8'($urandom & $urandom), 8'h96 ^ 8'($urandom & $urandom));
        end

        // ---------------- HOLD = 1 ----------------
        sweep(1, 8'hE8, 8'h96);
        sweep(1, 8'hE8, 8'h96 ^ 8'h20);
        for (int k = 0; k < 6; k++) begin
            sweep(1, 8'hE8 ^ 8'($urandom & $urandom), 8'h96 ^ 8'($urandom & $urandom));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
